scan_decoder: RTL and testbench
===============================

// Module: scan_decoder
// PURPOSE
//  Registered, parametrised one-hot select generator with handshake load and three modes:
//    LEVEL: hold a decoded select.
//    PULSE: one-cycle strobe.
//    SCAN:  timed sweep across every output.
//  Drives chip/row selects and strobe fan-out for peripheral banks from a single control FSM.
// PARAMETERS
//  WIDTH      16              number of one-hot outputs (>=2, need not be a power of 2)
//  ADDR_SIZE  $clog2(WIDTH)   select width (derived; do not override)
//  SCAN_HOLD  4               cycles each output stays high in SCAN mode (>=1)
// PORTS
//  clk      in   1          clock, rising edge
//  reset    in   1          asynchronous, active-high reset
//  enable   in   1          output gate; 0 forces out=0, internal state keeps running
//  load     in   1          request valid; accepted when load&ready
//  ready    out  1          block can accept a request
//  mode     in   2          0=LEVEL 1=PULSE 2=SCAN 3=reserved (treated as LEVEL)
//  sel      in   ADDR_SIZE  target index for LEVEL/PULSE; ignored for SCAN
//  out      out  WIDTH      one-hot (or zero) select, registered, then ANDed with enable
//  cur_sel  out  ADDR_SIZE  index currently driven (0 when out_q==0)
//  done     out  1          one-cycle pulse at end of a PULSE or SCAN sweep
// BEHAVIOUR
//  Reset: state=IDLE, out_q=0, cur_sel=0, done=0, ready=1, scan counters=0.
//    Reset mid-sweep aborts immediately, with no done pulse.
//  States:
//    IDLE:  ready=1, out_q=0.
//    LEVEL: ready=1, out_q=onehot(sel) held.
//    PULSE: ready=0, one cycle.
//    SCAN:  ready=0.
//  Accept (load&ready, edge N) -> out_q valid at edge N+1; latency 1 cycle.
//  LEVEL: out_q holds until next accepted load; a new LEVEL load replaces it with no zero gap.
//  PULSE: out_q=onehot(sel) for exactly 1 cycle, done=1 that cycle, then IDLE (out_q=0).
//  SCAN:
//    - idx=0 first; each idx held SCAN_HOLD cycles; idx increments to WIDTH-1.
//    - done=1 on the last hold cycle of WIDTH-1, then IDLE.
//    - Total WIDTH*SCAN_HOLD cycles high.
//  load while ready=0: ignored; the requester must keep load asserted.
//  load in LEVEL state: accepted; any mode transition allowed.
//  sel >= WIDTH (non-pow2 WIDTH): LEVEL/PULSE request accepted, out_q=0, cur_sel=0.
//    PULSE still pulses done.
//  enable=0: out=0 combinationally.
//    FSM/timers unaffected, so a scan continues silently and done still fires.
//  Counters: hold counter width $clog2(SCAN_HOLD+1); idx counter ADDR_SIZE bits.
//    No wrap past WIDTH-1 (terminal compare, not overflow).
//  Invariant: $onehot0(out) at all times.
// CONFIGURATION
//  SCAN_DECODER_ERR_EN defined:
//    - Adds output port `err` (1 bit).
//    - err pulses 1 cycle on acceptance of a LEVEL/PULSE with sel>=WIDTH, or of mode==3.
//    - err reset value 0.
//  Not defined: no err port; such requests behave as above silently.
// STRUCTURE
//  Package scan_decoder_pkg:
//    - mode_t enum {MODE_LEVEL, MODE_PULSE, MODE_SCAN, MODE_RSVD}.
//    - state_t enum {ST_IDLE, ST_LEVEL, ST_PULSE, ST_SCAN}.
//  Sub-module onehot_decode #(WIDTH):
//    - Combinational sel->one-hot, zero when out of range.
//    - Instanced once, fed by a mux of sel/scan idx.
// TESTING
//  1 reset=1 mid-stream, then released -> out=0, ready=1, done=0, cur_sel=0 the cycle after release.
//  2 LEVEL sel=5 -> out=16'h0020 one cycle after accept; hold 10 cycles.
//    Then LEVEL sel=9 -> out=16'h0200 with no zero cycle.
//  3 PULSE sel=15 -> out=16'h8000 for exactly 1 cycle, done=1 same cycle, ready=0 that cycle, then out=0.
//  4 SCAN, SCAN_HOLD=4 -> out walks 0x0001..0x8000, each 4 cycles.
//    64 cycles total, done on cycle 64, ready returns; load during sweep ignored.
//  5 SCAN with enable toggled low for cycles 10-20 -> out=0 there.
//    Sweep timing and done unchanged; reset at cycle 30 -> out=0, IDLE.
//  6 WIDTH=10, LEVEL sel=12 -> out=0.
//    With SCAN_DECODER_ERR_EN, err=1 for 1 cycle; without it, no err port and the bench compiles.
//  All tests: assert $onehot0(out) every cycle.

Source files
------------

// File: rtl/scan_decoder_pkg.sv
// ----------------------------------------------------------------------------
// scan_decoder_pkg
//   Shared types for the scan_decoder block.
//   mode_t  : request mode carried on the 2-bit mode input.
//   state_t : control FSM states.
//   state_ready() : which states can accept a new request.
// ----------------------------------------------------------------------------
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL = 2'd0,
        MODE_PULSE = 2'd1,
        MODE_SCAN  = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEVEL = 2'd1,
        ST_PULSE = 2'd2,
        ST_SCAN  = 2'd3
    } state_t;

    // IDLE and LEVEL are the only states that take a new request.
    function automatic logic state_ready(state_t s);
        return (s == ST_IDLE) || (s == ST_LEVEL);
    endfunction

endpackage

// File: rtl/scan_decoder_onehot.sv
// ----------------------------------------------------------------------------
// onehot_decode
//   Combinational index -> one-hot decoder. An index >= WIDTH (possible when
//   WIDTH is not a power of two) decodes to all zeros.
// Ports:
//   idx    in   ADDR_SIZE  index to decode
//   onehot out  WIDTH      one-hot result, or zero when idx is out of range
// ----------------------------------------------------------------------------
module onehot_decode #(
    parameter int WIDTH     = 16,
    parameter int ADDR_SIZE = $clog2(WIDTH)
) (
    input  logic [ADDR_SIZE-1:0] idx,
    output logic [WIDTH-1:0]     onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            onehot[i] = (idx == ADDR_SIZE'(i));
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// ----------------------------------------------------------------------------
// scan_decoder
//   Registered one-hot select generator with a load/ready handshake and three
//   modes: LEVEL (hold a decoded select), PULSE (one-cycle strobe) and SCAN
//   (sweep every output, SCAN_HOLD cycles each).
// Optional feature: define SCAN_DECODER_ERR_EN to add the 'err' output, which
//   pulses for one cycle when a reserved mode or an out-of-range LEVEL/PULSE
//   select is accepted.
// Ports:
//   clk      in   1          rising-edge clock
//   reset    in   1          asynchronous active-high reset
//   enable   in   1          output gate (0 forces out=0, FSM keeps running)
//   load     in   1          request valid, taken when load & ready
//   ready    out  1          block can accept a request
//   mode     in   2          0=LEVEL 1=PULSE 2=SCAN 3=reserved (acts as LEVEL)
//   sel      in   ADDR_SIZE  target index for LEVEL/PULSE
//   out      out  WIDTH      registered one-hot select gated by enable
//   cur_sel  out  ADDR_SIZE  index currently driven (0 when nothing is driven)
//   done     out  1          one-cycle pulse at the end of a PULSE or SCAN
//   err      out  1          (SCAN_DECODER_ERR_EN only) bad-request pulse
// ----------------------------------------------------------------------------
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ADDR_SIZE = $clog2(WIDTH),
    parameter int SCAN_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 load,
    output logic                 ready,
    input  logic [1:0]           mode,
    input  logic [ADDR_SIZE-1:0] sel,
    output logic [WIDTH-1:0]     out,
    output logic [ADDR_SIZE-1:0] cur_sel,
    output logic                 done
`ifdef SCAN_DECODER_ERR_EN
    ,
    output logic                 err
`endif
);

    localparam int                   HOLD_W    = $clog2(SCAN_HOLD + 1);
    localparam logic [ADDR_SIZE-1:0] LAST_IDX  = ADDR_SIZE'(WIDTH - 1);
    localparam logic [HOLD_W-1:0]    LAST_HOLD = HOLD_W'(SCAN_HOLD - 1);

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       out_q, out_d;
    logic [ADDR_SIZE-1:0]   cur_sel_q, cur_sel_d;
    logic [ADDR_SIZE-1:0]   idx_q, idx_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   done_q, done_d;
    logic                   ready_q, ready_d;

    mode_t                  req_mode;
    logic                   accept;
    logic [ADDR_SIZE-1:0]   dec_idx;
    logic [ADDR_SIZE-1:0]   dec_sel;
    logic [WIDTH-1:0]       dec_onehot;

    assign req_mode = mode_t'(mode);
    assign accept   = load & ready_q;

    // Next state and scan counters.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        if (accept) begin
            case (req_mode)
                MODE_PULSE: state_d = ST_PULSE;
                MODE_SCAN: begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                    hold_d  = '0;
                end
                default:    state_d = ST_LEVEL;  // LEVEL and reserved
            endcase
        end else begin
            case (state_q)
                ST_PULSE: state_d = ST_IDLE;
                ST_SCAN: begin
                    // Terminal compares on both counters: the index never wraps.
                    if (hold_q == LAST_HOLD) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_IDLE;
                        end else begin
                            idx_d  = idx_q + ADDR_SIZE'(1);
                            hold_d = '0;
                        end
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Single decoder, fed by the scan index while sweeping, else by sel.
    assign dec_idx = (state_d == ST_SCAN) ? idx_d : sel;
    assign dec_sel = (|dec_onehot) ? dec_idx : '0;

    onehot_decode #(
        .WIDTH     (WIDTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_decode (
        .idx    (dec_idx),
        .onehot (dec_onehot)
    );

    // Registered outputs for the coming cycle.
    always_comb begin
        out_d     = out_q;
        cur_sel_d = cur_sel_q;
        case (state_d)
            ST_IDLE: begin
                out_d     = '0;
                cur_sel_d = '0;
            end
            ST_LEVEL: begin
                // A held LEVEL only changes on a new accepted request.
                if (accept) begin
                    out_d     = dec_onehot;
                    cur_sel_d = dec_sel;
                end
            end
            default: begin
                out_d     = dec_onehot;
                cur_sel_d = dec_sel;
            end
        endcase
        done_d  = (state_d == ST_PULSE) ||
                  ((state_d == ST_SCAN) && (idx_d == LAST_IDX) && (hold_d == LAST_HOLD));
        ready_d = state_ready(state_d);
    end

`ifdef SCAN_DECODER_ERR_EN
    logic err_q, err_d;
    logic sel_bad;
    localparam logic [ADDR_SIZE:0] WIDTH_EXT = (ADDR_SIZE + 1)'(WIDTH);

    // Extra bit so the compare also works when WIDTH == 2**ADDR_SIZE.
    assign sel_bad = ({1'b0, sel} >= WIDTH_EXT);
    assign err_d   = accept && ((req_mode == MODE_RSVD) ||
                     (((req_mode == MODE_LEVEL) || (req_mode == MODE_PULSE)) && sel_bad));
    assign err     = err_q;
`endif

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            out_q     <= '0;
            cur_sel_q <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
`ifdef SCAN_DECODER_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            cur_sel_q <= cur_sel_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
`ifdef SCAN_DECODER_ERR_EN
            err_q     <= err_d;
`endif
        end
    end

    // Gate is after the register so internal state keeps running when low.
    assign out     = out_q & {WIDTH{enable}};
    assign cur_sel = cur_sel_q;
    assign done    = done_q;
    assign ready   = ready_q;

endmodule

// File: tb/tb_scan_decoder.sv
// ----------------------------------------------------------------------------
// tb_scan_decoder
//   Directed bench for scan_decoder. Two instances: dut16 (WIDTH=16,
//   SCAN_HOLD=4) and dut10 (WIDTH=10, SCAN_HOLD=1). Stimulus pushes
//   hand-computed expected outputs, tagged with the cycle they apply to, into
//   a scoreboard queue; a monitor on the falling edge pops and compares.
// ----------------------------------------------------------------------------
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       load;
    logic       load10;
    logic [1:0] mode;
    logic [3:0] sel;

    logic        ready16, done16;
    logic [15:0] out16;
    logic [3:0]  cur16;
    logic        ready10, done10;
    logic [9:0]  out10;
    logic [3:0]  cur10;
`ifdef SCAN_DECODER_ERR_EN
    logic        err16, err10;
`endif

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          cyc;
        bit          u10;
        string       name;
        logic [15:0] out;
        logic [3:0]  cur;
        logic        done;
        logic        ready;
        logic        err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    scan_decoder #(.WIDTH(16), .SCAN_HOLD(4)) dut16 (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .load    (load),
        .ready   (ready16),
        .mode    (mode),
        .sel     (sel),
        .out     (out16),
        .cur_sel (cur16),
        .done    (done16)
`ifdef SCAN_DECODER_ERR_EN
        ,
        .err     (err16)
`endif
    );

    scan_decoder #(.WIDTH(10), .SCAN_HOLD(1)) dut10 (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .load    (load10),
        .ready   (ready10),
        .mode    (mode),
        .sel     (sel),
        .out     (out10),
        .cur_sel (cur10),
        .done    (done10)
`ifdef SCAN_DECODER_ERR_EN
        ,
        .err     (err10)
`endif
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(int d, bit u10, string name, logic [15:0] o, logic [3:0] cs,
                        logic dn, logic rd, logic er);
        exp_t e;
        e.cyc   = cyc + d;
        e.u10   = u10;
        e.name  = name;
        e.out   = o;
        e.cur   = cs;
        e.done  = dn;
        e.ready = rd;
        e.err   = er;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: one-hot invariant every cycle, plus scoreboard entries due now.
    always @(negedge clk) begin
        check("onehot0_out16", 32'($onehot0(out16)), 32'd1);
        check("onehot0_out10", 32'($onehot0(out10)), 32'd1);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                if (sb[i].u10) begin
                    check($sformatf("%s.out", sb[i].name),     32'(out10),   32'(sb[i].out));
                    check($sformatf("%s.cur_sel", sb[i].name), 32'(cur10),   32'(sb[i].cur));
                    check($sformatf("%s.done", sb[i].name),    32'(done10),  32'(sb[i].done));
                    check($sformatf("%s.ready", sb[i].name),   32'(ready10), 32'(sb[i].ready));
`ifdef SCAN_DECODER_ERR_EN
                    check($sformatf("%s.err", sb[i].name),     32'(err10),   32'(sb[i].err));
`endif
                end else begin
                    check($sformatf("%s.out", sb[i].name),     32'(out16),   32'(sb[i].out));
                    check($sformatf("%s.cur_sel", sb[i].name), 32'(cur16),   32'(sb[i].cur));
                    check($sformatf("%s.done", sb[i].name),    32'(done16),  32'(sb[i].done));
                    check($sformatf("%s.ready", sb[i].name),   32'(ready16), 32'(sb[i].ready));
`ifdef SCAN_DECODER_ERR_EN
                    check($sformatf("%s.err", sb[i].name),     32'(err16),   32'(sb[i].err));
`endif
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL %s: expected at cycle %0d, never sampled", sb[i].name, sb[i].cyc);
                sb.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        load   = 1'b0;
        load10 = 1'b0;
        mode   = 2'd0;
        sel    = 4'd0;
        step();
        step();
        reset = 1'b0;

        // 1: reset in the middle of a held LEVEL.
        mode = 2'd0; sel = 4'd3; load = 1'b1;
        push(1, 0, "t1_level3", 16'h0008, 4'd3, 1'b0, 1'b1, 1'b0);
        step();
        load = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        step();
        reset = 1'b0;
        push(0, 0, "t1_post_reset0", 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0);
        push(1, 0, "t1_post_reset1", 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0);
        step();

        // 2: LEVEL 5 held 10 cycles, then LEVEL 9 with no zero gap.
        mode = 2'd0; sel = 4'd5; load = 1'b1;
        for (int k = 1; k <= 10; k++)
            push(k, 0, $sformatf("t2_lvl5_c%0d", k), 16'h0020, 4'd5, 1'b0, 1'b1, 1'b0);
        push(11, 0, "t2_lvl9_nogap", 16'h0200, 4'd9, 1'b0, 1'b1, 1'b0);
        step();
        load = 1'b0;
        repeat (9) step();
        sel = 4'd9; load = 1'b1;
        step();
        load = 1'b0;

        // 3: PULSE 15 from LEVEL.
        mode = 2'd1; sel = 4'd15; load = 1'b1;
        push(1, 0, "t3_pulse15", 16'h8000, 4'd15, 1'b1, 1'b0, 1'b0);
        push(2, 0, "t3_after",   16'h0000, 4'd0,  1'b0, 1'b1, 1'b0);
        push(3, 0, "t3_idle",    16'h0000, 4'd0,  1'b0, 1'b1, 1'b0);
        step();
        load = 1'b0;
        step();
        step();

        // 4: full SCAN; a LEVEL 2 request held during the sweep lands after it.
        mode = 2'd2; load = 1'b1;
        for (int k = 0; k < 64; k++)
            push(k + 1, 0, $sformatf("t4_scan_%0d", k), 16'h0001 << (k / 4), 4'(k / 4),
                 (k == 63), 1'b0, 1'b0);
        push(65, 0, "t4_idle",         16'h0000, 4'd0, 1'b0, 1'b1, 1'b0);
        push(66, 0, "t4_queued_level", 16'h0004, 4'd2, 1'b0, 1'b1, 1'b0);
        step();
        mode = 2'd0; sel = 4'd2;
        repeat (65) step();
        load = 1'b0;

        // 5: SCAN with enable low for sweep cycles 10..20, reset at cycle 30.
        mode = 2'd2; load = 1'b1;
        for (int k = 1; k <= 30; k++)
            push(k, 0, $sformatf("t5_scan_c%0d", k),
                 (k >= 10 && k <= 20) ? 16'h0000 : (16'h0001 << ((k - 1) / 4)),
                 4'((k - 1) / 4), 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            step();
            load   = 1'b0;
            enable = !(k >= 10 && k <= 20);
        end
        @(negedge clk);
        #1 reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 40; k++)
            push(k, 0, $sformatf("t5_reset_idle_%0d", k), 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0);
        repeat (40) step();

        // 6: WIDTH=10 out-of-range selects, reserved mode, SCAN_HOLD=1 sweep.
        mode = 2'd0; sel = 4'd12; load10 = 1'b1;
        push(1, 1, "t6_level_oor", 16'h0000, 4'd0, 1'b0, 1'b1, 1'b1);
        step();
        mode = 2'd1;
        push(1, 1, "t6_pulse_oor", 16'h0000, 4'd0, 1'b1, 1'b0, 1'b1);
        step();
        load10 = 1'b0;
        push(1, 1, "t6_idle", 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0);
        step();
        mode = 2'd3; sel = 4'd4; load10 = 1'b1;
        push(1, 1, "t6_rsvd_level4", 16'h0010, 4'd4, 1'b0, 1'b1, 1'b1);
        step();
        mode = 2'd2;
        for (int k = 0; k < 10; k++)
            push(k + 1, 1, $sformatf("t6_scan_%0d", k), 16'h0001 << k, 4'(k),
                 (k == 9), 1'b0, 1'b0);
        push(11, 1, "t6_scan_end", 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0);
        step();
        load10 = 1'b0;
        repeat (12) step();

        repeat (3) step();
        @(negedge clk);
        #1;
        foreach (sb[i]) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: expected at cycle %0d, never sampled", sb[i].name, sb[i].cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
